// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI4 widths, encodings and master state enum
package axi_pkg;
  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_SIZE_W-1:0]  SIZE_WORD   = 3'b010;
  localparam logic [1:0]             RESP_OKAY   = 2'b00;
  localparam logic [1:0]             RESP_SLVERR = 2'b10;
  localparam logic [1:0]             RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B} state_e;
endpackage

// File: rtl/axi_read_write_master.sv
// axi_read_write_master: turns a simple core request into an AXI4 read burst or single-beat write
module axi_read_write_master
  import axi_pkg::*;
#(
  parameter logic [AXI_ID_W-1:0] MASTER_ID = 4'h0,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic [LEN_W-1:0]       core_len,
  input  logic [DATA_W/8-1:0]    core_wstrb,
  input  logic [DATA_W-1:0]      core_wdata,
  output logic                   core_stall,
  output logic                   core_rvalid,
  output logic [DATA_W-1:0]      core_rdata,
  output logic                   core_done,
  output logic                   core_err,
  output logic [AXI_ID_W-1:0]    arid,
  output logic [ADDR_W-1:0]      araddr,
  output logic [LEN_W-1:0]       arlen,
  output logic [AXI_SIZE_W-1:0]  arsize,
  output logic [AXI_BURST_W-1:0] arburst,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [AXI_ID_W-1:0]    rid,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [AXI_ID_W-1:0]    awid,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [LEN_W-1:0]       awlen,
  output logic [AXI_SIZE_W-1:0]  awsize,
  output logic [AXI_BURST_W-1:0] awburst,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_W-1:0]      wdata,
  output logic [DATA_W/8-1:0]    wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [AXI_ID_W-1:0]    bid,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready
);
  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d, cnt_q, cnt_d;
  logic [DATA_W/8-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 r_bad;

  // rlast must coincide exactly with the len-th beat; any other pairing is a protocol error
  assign r_bad = (rresp != RESP_OKAY) || (rid != MASTER_ID) || (rlast != (cnt_q == len_q));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    core_rvalid = 1'b0;
    core_done   = 1'b0;
    case (state_q)
      ST_IDLE: if (core_req) begin
        addr_d  = core_addr;
        len_d   = core_len;
        wstrb_d = core_wstrb;
        wdata_d = core_wdata;
        err_d   = 1'b0;
        state_d = core_we ? ST_AW : ST_AR;
      end
      ST_AR: state_d = arready ? ST_R : ST_AR;
      ST_R: if (rvalid) begin
        core_rvalid = 1'b1;
        cnt_d       = rlast ? '0 : cnt_q + 1'b1;
        err_d       = err_q | r_bad;
        core_done   = rlast;
        state_d     = rlast ? ST_IDLE : ST_R;
      end
      ST_AW: state_d = awready ? ST_W : ST_AW;
      ST_W:  state_d = wready ? ST_B : ST_W;
      ST_B: if (bvalid) begin
        core_done = 1'b1;
        err_d     = err_q | (bresp != RESP_OKAY) | (bid != MASTER_ID);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign core_stall = (state_q != ST_IDLE) | core_req;
  assign core_rdata = rdata;
  assign core_err   = err_q;
  assign arid       = MASTER_ID;
  assign araddr     = addr_q;
  assign arlen      = len_q;
  assign arsize     = SIZE_WORD;
  assign arburst    = BURST_INCR;
  assign arvalid    = state_q == ST_AR;
  assign rready     = state_q == ST_R;
  assign awid       = MASTER_ID;
  assign awaddr     = addr_q;
  assign awlen      = '0;
  assign awsize     = SIZE_WORD;
  assign awburst    = BURST_INCR;
  assign awvalid    = state_q == ST_AW;
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wlast      = state_q == ST_W;
  assign wvalid     = state_q == ST_W;
  assign bready     = state_q == ST_B;
endmodule

// File: tb/tb_axi_read_write_master.sv
// tb_axi_read_write_master: directed vector table plus reset-mid-burst sequence
module tb_axi_read_write_master;
  import axi_pkg::*;
  localparam logic [3:0] MID = 4'h3;
  logic clk = 1'b0, rst = 1'b0;
  logic core_req = 0, core_we = 0;
  logic [31:0] core_addr = 0, core_wdata = 0;
  logic [3:0] core_len = 0, core_wstrb = 0;
  logic core_stall, core_rvalid, core_done, core_err;
  logic [31:0] core_rdata;
  logic [3:0] arid, awid, arlen, awlen;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst;
  logic arvalid, awvalid, wvalid, wlast, rready, bready;
  logic [3:0] wstrb;
  logic arready = 0, awready = 0, wready = 0, rvalid = 0, rlast = 0, bvalid = 0;
  logic [3:0] rid = 0, bid = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0, bresp = 0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  axi_read_write_master #(.MASTER_ID(MID)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_len(core_len), .core_wstrb(core_wstrb), .core_wdata(core_wdata), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_done(core_done), .core_err(core_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    int          beats;
    int          gap;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        exp_err;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t t);
    @(negedge clk);
    core_req = 1; core_we = t.we; core_addr = t.addr; core_len = t.len;
    core_wdata = t.data; core_wstrb = t.strb;
    #1;
    chk("req_stall", core_stall, 1);
    chk("req_no_valid", {arvalid, awvalid}, 0);
    for (int k = 0; k <= t.dly; k++) begin
      @(negedge clk);
      core_req = 0;
      if (t.we) awready = (k == t.dly); else arready = (k == t.dly);
      #1;
      chk("err_cleared", core_err, 0);
      chk("stall_busy", core_stall, 1);
      if (t.we) begin
        chk("awvalid", awvalid, 1);
        chk("awaddr", awaddr, t.addr);
        chk("aw_len_size_burst_id", {awlen, awsize, awburst, awid}, {4'd0, 3'b010, 2'b01, MID});
      end else begin
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, t.addr);
        chk("ar_len_size_burst_id", {arlen, arsize, arburst, arid}, {t.len, 3'b010, 2'b01, MID});
      end
    end
    if (t.we) begin
      @(negedge clk);
      awready = 0; wready = 1;
      #1;
      chk("w_valid_last", {awvalid, wvalid, wlast}, 3'b011);
      chk("w_data_strb", {wdata, wstrb}, {t.data, t.strb});
      @(negedge clk);
      wready = 0; bvalid = 1; bresp = t.resp; bid = t.id;
      #1;
      chk("bready", {wvalid, bready}, 2'b01);
      chk("b_done", core_done, 1);
    end else begin
      for (int b = 0; b < t.beats; b++) begin
        for (int g = 0; g < t.gap; g++) begin
          @(negedge clk);
          arready = 0; rvalid = 0;
          #1;
          chk("r_gap_quiet", {rready, core_rvalid, core_done, core_stall}, 4'b1001);
        end
        @(negedge clk);
        arready = 0; rvalid = 1; rdata = t.data + 32'(b); rlast = (b == t.beats - 1);
        rresp = t.resp; rid = t.id;
        #1;
        chk("r_beat_valid", {arvalid, rready, core_rvalid}, 3'b011);
        chk("r_beat_data", core_rdata, t.data + 32'(b));
        chk("r_beat_done", core_done, (b == t.beats - 1));
      end
    end
    @(negedge clk);
    rvalid = 0; rlast = 0; bvalid = 0; rresp = 0; bresp = 0;
    #1;
    chk("post_idle", {core_stall, core_done, core_rvalid, arvalid, awvalid, bready, rready}, 0);
    chk("post_err", core_err, t.exp_err);
  endtask

  initial begin
    //             we addr          len data          strb dly bts gap resp         id   err
    vecs[0] = '{1'b0, 32'h10,   4'd0, 32'hDEADBEEF, 4'h0, 2, 1, 0, RESP_OKAY,   MID, 1'b0};
    vecs[1] = '{1'b0, 32'h100,  4'd3, 32'hA0,       4'h0, 0, 4, 1, RESP_OKAY,   MID, 1'b0};
    vecs[2] = '{1'b1, 32'h2000, 4'd0, 32'h12345678, 4'h3, 3, 0, 0, RESP_OKAY,   MID, 1'b0};
    vecs[3] = '{1'b0, 32'h40,   4'd0, 32'h55,       4'h0, 1, 1, 0, RESP_SLVERR, MID, 1'b1};
    vecs[4] = '{1'b1, 32'h3000, 4'd0, 32'hCAFEF00D, 4'hF, 0, 0, 0, RESP_DECERR, MID, 1'b1};
    vecs[5] = '{1'b0, 32'h80,   4'd1, 32'h700,      4'h0, 0, 2, 0, RESP_OKAY,   MID, 1'b0};
    vecs[6] = '{1'b0, 32'h200,  4'd3, 32'hB0,       4'h0, 0, 2, 0, RESP_OKAY,   MID, 1'b1};
    vecs[7] = '{1'b0, 32'h300,  4'd0, 32'hC0,       4'h0, 0, 2, 0, RESP_OKAY,   MID, 1'b1};
    vecs[8] = '{1'b0, 32'h400,  4'd0, 32'hD0,       4'h0, 0, 1, 0, RESP_OKAY,   4'h5, 1'b1};
    #12;
    chk("reset_outputs", {arvalid, awvalid, wvalid, rready, bready, core_rvalid, core_done, core_err, core_stall}, 0);
    chk("reset_addr", {araddr, wdata, wstrb}, 0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 9; i++) run_txn(vecs[i]);
    // reset asserted while the second beat of a burst is on the bus
    @(negedge clk);
    core_req = 1; core_we = 0; core_addr = 32'h500; core_len = 4'd3;
    @(negedge clk);
    core_req = 0; arready = 1;
    @(negedge clk);
    arready = 0; rvalid = 1; rdata = 32'hE0; rlast = 0; rid = MID; rresp = RESP_OKAY;
    #1;
    chk("rst_pre_beat", core_rvalid, 1);
    @(negedge clk);
    rdata = 32'hE1; rst = 0;
    #1;
    chk("rst_mid_quiet", {arvalid, awvalid, wvalid, rready, bready, core_rvalid, core_done, core_stall}, 0);
    @(negedge clk);
    rvalid = 0; rst = 1;
    #1;
    chk("rst_after_quiet", {core_done, core_err, core_stall}, 0);
    run_txn(vecs[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
